// File: rtl/accum1d_driver.sv
// accum1d_driver: FIFO-buffered initiator for the Accum1D en/done four-phase add handshake.
// Define ACCUM1D_DRV_CHECK_EN to build the shadow-sum checker driving expected/mismatch.
module accum1d_driver #(
    parameter int ACCUM_WIDTH    = 256,
    parameter int ADD_WIDTH      = 128,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ADD_WIDTH-1:0]   in_data,
    output logic                   en,
    output logic [ADD_WIDTH-1:0]   add,
    input  logic                   done,
    input  logic [ACCUM_WIDTH-1:0] accum,
    output logic                   busy,
    output logic [31:0]            txn_count,
    output logic                   timeout_err,
    output logic                   mismatch,
    output logic [ACCUM_WIDTH-1:0] expected
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int WW = $clog2(TIMEOUT_CYCLES);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_REL} state_t;

    state_t                 state_q;
    logic                   en_q;
    logic [ADD_WIDTH-1:0]   add_q;
    logic [31:0]            txn_q;
    logic                   to_q;
    logic [WW-1:0]          wd_q;

    logic [ADD_WIDTH-1:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [AW:0]            cnt_q, cnt_d;
    logic                   push, pop, empty, full;

    assign full     = (cnt_q == (AW+1)'(FIFO_DEPTH));
    assign empty    = (cnt_q == '0);
    assign in_ready = !full;
    assign push     = in_valid && !full;
    // A stale acknowledge still high in IDLE blocks the next issue.
    assign pop      = (state_q == S_IDLE) && !empty && !done;
    assign cnt_d    = cnt_q + (AW+1)'(push) - (AW+1)'(pop);

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            en_q    <= 1'b0;
            add_q   <= '0;
            txn_q   <= '0;
            to_q    <= 1'b0;
            wd_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        add_q   <= mem_q[rd_ptr_q];
                        en_q    <= 1'b1;
                        wd_q    <= '0;
                        state_q <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (done) begin
                        en_q    <= 1'b0;
                        wd_q    <= '0;
                        state_q <= S_REL;
                    end else if (wd_q == WD_LAST) begin
                        to_q    <= 1'b1;
                        en_q    <= 1'b0;
                        wd_q    <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        wd_q <= wd_q + WW'(1);
                    end
                end
                S_REL: begin
                    if (!done) begin
                        txn_q   <= txn_q + 32'd1;
                        wd_q    <= '0;
                        state_q <= S_IDLE;
                    end else if (wd_q == WD_LAST) begin
                        to_q    <= 1'b1;
                        wd_q    <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        wd_q <= wd_q + WW'(1);
                    end
                end
                default: begin
                    en_q    <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef ACCUM1D_DRV_CHECK_EN
    logic [ACCUM_WIDTH-1:0] exp_q, exp_d;
    logic                   mis_q;

    assign exp_d = exp_q + ACCUM_WIDTH'(add_q);

    // Shadow sum follows the accumulator only on acknowledged adds.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_q <= '0;
            mis_q <= 1'b0;
        end else if (state_q == S_REQ && done) begin
            exp_q <= exp_d;
            mis_q <= mis_q | (accum != exp_d);
        end
    end

    assign expected = exp_q;
    assign mismatch = mis_q;
`else
    logic accum_unused;
    assign accum_unused = ^accum;
    assign expected     = '0;
    assign mismatch     = 1'b0;
`endif

    assign en          = en_q;
    assign add         = add_q;
    assign txn_count   = txn_q;
    assign timeout_err = to_q;
    assign busy        = (state_q != S_IDLE) || !empty;

endmodule

// File: tb/tb_accum1d_driver.sv
// Self-checking bench for accum1d_driver: behavioural responder plus a sum/count/order model.
module tb_accum1d_driver;
    localparam int  W    = 32;
    localparam int  TO   = 16;
`ifdef ACCUM1D_DRV_CHECK_EN
    localparam bit  CHK  = 1'b1;
`else
    localparam bit  CHK  = 1'b0;
`endif
    localparam longint MASK = 64'hFFFF_FFFF;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         en;
    logic [W-1:0] add;
    logic         done;
    logic [W-1:0] accum;
    logic         busy;
    logic [31:0]  txn_count;
    logic         timeout_err;
    logic         mismatch;
    logic [W-1:0] expected;

    accum1d_driver #(
        .ACCUM_WIDTH(W), .ADD_WIDTH(W), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .en(en), .add(add), .done(done), .accum(accum),
        .busy(busy), .txn_count(txn_count), .timeout_err(timeout_err),
        .mismatch(mismatch), .expected(expected)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Responder: accumulator model with optional stall, corruption and random latency.
    logic         hold = 1'b0, corrupt = 1'b0, rand_lat = 1'b0;
    logic [W-1:0] acc_r;
    int           dly;
    assign accum = acc_r;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            done  <= 1'b0;
            acc_r <= '0;
            dly   <= 0;
        end else if (!hold) begin
            if (en && !done) begin
                if (dly > 0) dly <= dly - 1;
                else begin
                    acc_r <= acc_r + add + W'(corrupt);
                    done  <= 1'b1;
                    dly   <= rand_lat ? int'($urandom_range(0, 3)) : 0;
                end
            end else if (!en && done) begin
                done <= 1'b0;
            end
        end
    end

    // Reference model: issue order, completed-sum and completed-count.
    logic [W-1:0] exp_q[$];
    int           rise_cyc[$];
    longint       m_sum = 0;
    longint       m_cnt = 0;
    logic         m_mis = 1'b0, m_to = 1'b0, en_prev = 1'b0;
    logic [W-1:0] head;
    always @(negedge clk) begin
        if (en && !en_prev) begin
            rise_cyc.push_back(cyc);
            if (exp_q.size() == 0) chk("issue_unexpected", 1, 0);
            else begin
                head = exp_q.pop_front();
                chk("add_order", add, head);
                if (!hold) begin
                    m_sum = (m_sum + longint'(head)) & MASK;
                    m_cnt = (m_cnt + 1) & MASK;
                    if (corrupt) m_mis = 1'b1;
                end
            end
        end
        en_prev = en;
    end

    task automatic push(input logic [W-1:0] v);
        int n = 0;
        while (!in_ready && n < 300) begin @(negedge clk); n++; end
        chk("push_ready", in_ready, 1);
        in_valid = 1'b1;
        in_data  = v;
        exp_q.push_back(v);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge clk);
        while ((busy || en || done) && n < 1000) begin @(negedge clk); n++; end
        chk({tag, "_idle"}, {busy, en, done}, 0);
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_cnt"}, txn_count, m_cnt);
        chk({tag, "_exp"}, expected, CHK ? m_sum : 64'd0);
        chk({tag, "_mis"}, mismatch, CHK ? m_mis : 1'b0);
        chk({tag, "_to"}, timeout_err, m_to);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int base, n;
        longint c0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_en", en, 0);
        chk("rst_add", add, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", in_ready, 1);
        check_state("rst");

        // 1: single add
        push(32'h5);
        chk("t1_ready", in_ready, 1);
        wait_idle("t1");
        check_state("t1");

        // 2: back-to-back pushes fill the FIFO behind an in-flight add; 5 cycles per add
        base = rise_cyc.size();
        for (int i = 1; i <= 5; i++) push(W'(i));
        chk("t2_full", in_ready, 0);
        wait_idle("t2");
        for (int i = 1; i < 5; i++) chk("t2_gap", 64'(rise_cyc[base+i] - rise_cyc[base+i-1]), 5);
        check_state("t2");

        // 3: stalled responder times out, queued entry then completes
        c0 = m_cnt;
        hold = 1'b1;
        push(32'h77);
        push(32'h3);
        n = 0;
        while (en && n < 200) begin @(negedge clk); n++; end
        hold = 1'b0;
        m_to = 1'b1;
        chk("t3_en_low", en, 0);
        chk("t3_to_len", 64'(cyc - rise_cyc[rise_cyc.size()-1]), TO);
        chk("t3_to_flag", timeout_err, 1);
        chk("t3_cnt_held", txn_count, c0);
        wait_idle("t3");
        check_state("t3");

        // 4: responder off by one
        corrupt = 1'b1;
        push(32'h10);
        wait_idle("t4a");
        corrupt = 1'b0;
        check_state("t4a");
        push(32'h20);
        wait_idle("t4b");
        check_state("t4b");

        // 5: reset during REQ with two entries queued
        hold = 1'b1;
        push(32'hA1); push(32'hA2); push(32'hA3);
        n = 0;
        while (!en && n < 50) begin @(negedge clk); n++; end
        chk("t5_in_req", en, 1);
        reset = 1'b1;
        #1;
        chk("t5_en", en, 0);
        chk("t5_busy", busy, 0);
        chk("t5_cnt", txn_count, 0);
        exp_q.delete();
        m_sum = 0; m_cnt = 0; m_mis = 1'b0; m_to = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        hold  = 1'b0;
        base = rise_cyc.size();
        repeat (20) @(negedge clk);
        chk("t5_no_issue", rise_cyc.size() - base, 0);
        check_state("t5");

        // 6: sum and count wrap
        force dut.txn_q = 32'hFFFF_FFFE;
        #1 release dut.txn_q;
        m_cnt = 64'hFFFF_FFFE;
        push(32'hFFFF_FFFF);
        wait_idle("t6a");
        check_state("t6a");
        push(32'hFFFF_FFFF);
        wait_idle("t6b");
        chk("t6_cnt_wrap", txn_count, 0);
        check_state("t6b");

        // 7: random addends, gaps and responder latency
        rand_lat = 1'b1;
        for (int i = 0; i < 24; i++) begin
            push($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle("t7");
        check_state("t7");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
